// File: rtl/bit_serial_subtractor.sv
// LSB-first bit-serial subtractor: one full-subtractor cell, one bit per clock, registered borrow.
// Optional SUB_SATURATE_EN clamps the difference to zero when the final borrow is set.
module bit_serial_subtractor #(
  parameter int DATA_W = 8
) (
  input  logic              s_clk,
  input  logic              s_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_minuend,
  input  logic [DATA_W-1:0] i_subtrahend,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_diff,
  output logic              o_borrow
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg;
  logic [DATA_W-1:0]   a_sr_reg;
  logic [DATA_W-1:0]   b_sr_reg;
  logic [DATA_W-1:0]   res_sr_reg;
  logic                borrow_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                ready_reg;
  logic                valid_reg;
  logic [DATA_W-1:0]   diff_reg;
  logic                borrow_out_reg;

  logic                bit_a;
  logic                bit_b;
  logic                d_bit;
  logic                bout;
  logic                last_bit;
  logic [DATA_W-1:0]   res_next;
  logic [DATA_W-1:0]   diff_next;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    bit_a    = a_sr_reg[0];
    bit_b    = b_sr_reg[0];
    d_bit    = bit_a ^ bit_b ^ borrow_reg;
    bout     = (~bit_a & bit_b) | (borrow_reg & ~(bit_a ^ bit_b));
    last_bit = (cnt_reg == CNT_W'(DATA_W - 1));
    res_next = {d_bit, res_sr_reg[DATA_W-1:1]};
`ifdef SUB_SATURATE_EN
    diff_next = bout ? '0 : res_next;
`else
    diff_next = res_next;
`endif
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_reg      <= IDLE;
      a_sr_reg       <= '0;
      b_sr_reg       <= '0;
      res_sr_reg     <= '0;
      borrow_reg     <= 1'b0;
      cnt_reg        <= '0;
      ready_reg      <= 1'b1;
      valid_reg      <= 1'b0;
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_valid && ready_reg) begin
            a_sr_reg   <= i_minuend;
            b_sr_reg   <= i_subtrahend;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            ready_reg  <= 1'b0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          res_sr_reg <= res_next;
          borrow_reg <= bout;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (last_bit) begin
            diff_reg       <= diff_next;
            borrow_out_reg <= bout;
            valid_reg      <= 1'b1;
            state_reg      <= DONE;
          end
        end
        DONE: begin
          // Result held until downstream takes it; ready returns one cycle later
          if (valid_reg && i_ready) begin
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready  = ready_reg;
  assign o_valid  = valid_reg;
  assign o_diff   = diff_reg;
  assign o_borrow = borrow_out_reg;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed + randomised bench for bit_serial_subtractor (DATA_W=8), honours SUB_SATURATE_EN.
module tb_bit_serial_subtractor;

  localparam int DATA_W = 8;

  logic              s_clk = 1'b0;
  logic              s_rst_n;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_minuend;
  logic [DATA_W-1:0] i_subtrahend;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_diff;
  logic              o_borrow;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 s_clk = ~s_clk;

  bit_serial_subtractor #(.DATA_W(DATA_W)) dut (
    .s_clk        (s_clk),
    .s_rst_n      (s_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_minuend    (i_minuend),
    .i_subtrahend (i_subtrahend),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_diff       (o_diff),
    .o_borrow     (o_borrow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge s_clk);
    #1;
  endtask

  // One full transaction; gap_ready cycles of backpressure in DONE with i_valid toggling
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit early,
                       input int gap_ready, input string tag);
    logic [7:0] ed;
    logic       eb;
    int         lat;
    int         wait_c;
    eb = (a < b);
    ed = a - b;
`ifdef SUB_SATURATE_EN
    if (eb) ed = 8'd0;
`endif
    wait_c = 0;
    while (!o_ready && wait_c < 40) begin
      step();
      wait_c++;
    end
    check({tag, " ready_before"}, 32'(o_ready), 32'd1);
    i_valid      = 1'b1;
    i_minuend    = a;
    i_subtrahend = b;
    i_ready      = early;
    step();
    i_valid      = 1'b0;
    i_minuend    = 8'($urandom);
    i_subtrahend = 8'($urandom);
    check({tag, " ready_busy"}, 32'(o_ready), 32'd0);
    lat = 0;
    while (!o_valid && lat < 40) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd8);
    check({tag, " diff"}, 32'(o_diff), 32'(ed));
    check({tag, " borrow"}, 32'(o_borrow), 32'(eb));
    if (!early) begin
      for (int k = 0; k < gap_ready; k++) begin
        i_valid      = ~i_valid;
        i_minuend    = 8'($urandom);
        i_subtrahend = 8'($urandom);
        step();
        check({tag, " hold_valid"}, 32'(o_valid), 32'd1);
        check({tag, " hold_ready"}, 32'(o_ready), 32'd0);
        check({tag, " hold_diff"}, 32'(o_diff), 32'(ed));
        check({tag, " hold_borrow"}, 32'(o_borrow), 32'(eb));
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
    end
    $display("[TB] %s A=%0d B=%0d diff=%0d borrow=%0d latency=%0d", tag, a, b, o_diff, o_borrow, lat);
    step();
    i_ready = 1'b0;
    check({tag, " valid_after_hs"}, 32'(o_valid), 32'd0);
    check({tag, " ready_after_hs"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic seen_valid;
    s_rst_n      = 1'b0;
    i_valid      = 1'b0;
    i_ready      = 1'b0;
    i_minuend    = '0;
    i_subtrahend = '0;
    #12;
    check("reset ready", 32'(o_ready), 32'd1);
    check("reset valid", 32'(o_valid), 32'd0);
    check("reset diff", 32'(o_diff), 32'd0);
    check("reset borrow", 32'(o_borrow), 32'd0);
    step();
    s_rst_n = 1'b1;
    step();

    do_op(8'd200, 8'd55,  1'b0, 0, "basic");
    do_op(8'd5,   8'd10,  1'b0, 0, "underflow");
    do_op(8'd255, 8'd255, 1'b0, 0, "equal_max");
    do_op(8'd0,   8'd0,   1'b0, 0, "zero_zero");
    do_op(8'd0,   8'd255, 1'b0, 0, "zero_minus_max");
    do_op(8'd128, 8'd1,   1'b1, 0, "early_ready");
    do_op(8'd37,  8'd200, 1'b0, 5, "backpressure");
    seen_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (o_valid) seen_valid = 1'b1;
    end
    check("no_take_during_bp", 32'(seen_valid), 32'd0);

    // Reset in the middle of a run
    do_op(8'd9, 8'd4, 1'b0, 0, "pre_reset");
    i_valid      = 1'b1;
    i_minuend    = 8'd7;
    i_subtrahend = 8'd3;
    step();
    i_valid = 1'b0;
    repeat (3) step();
    s_rst_n = 1'b0;
    #1;
    check("midrun_reset ready", 32'(o_ready), 32'd1);
    check("midrun_reset valid", 32'(o_valid), 32'd0);
    check("midrun_reset diff", 32'(o_diff), 32'd0);
    check("midrun_reset borrow", 32'(o_borrow), 32'd0);
    step();
    s_rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (o_valid) seen_valid = 1'b1;
    end
    check("midrun_reset no_pulse", 32'(seen_valid), 32'd0);
    do_op(8'd100, 8'd1, 1'b0, 0, "after_reset");

    for (int n = 0; n < 1000; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      repeat ($urandom_range(0, 3)) step();
      do_op(ra, rb, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
